// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared single-port
// 8x8 register file. One access (write or two-operand read) per three cycles:
// IDLE samples and arbitrates, ACCESS drives the regfile, RESP returns rvalid.
module regfile_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr1_0,
  input  logic [ADDR_W-1:0] addr1_1,
  input  logic [ADDR_W-1:0] addr2_0,
  input  logic [ADDR_W-1:0] addr2_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] rf_r_addr1,
  output logic [ADDR_W-1:0] rf_r_addr2,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              rf_r_or_w,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last;
  logic              win;
  logic              lat_sel;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_a1;
  logic [ADDR_W-1:0] lat_a2;
  logic [DATA_W-1:0] lat_wd;

  // Round-robin winner: a lone requester wins; on a tie the one that did not win last time
  always_comb begin
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE waits for a request, then ACCESS and RESP take one cycle each
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req != 2'b00) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request, update priority, and capture read data at the end of ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      last    <= 1'b1;
      lat_sel <= 1'b0;
      lat_we  <= 1'b0;
      lat_a1  <= '0;
      lat_a2  <= '0;
      lat_wd  <= '0;
      rdata1  <= '0;
      rdata2  <= '0;
    end else begin
      if (state == IDLE && req != 2'b00) begin
        last    <= win;
        lat_sel <= win;
        lat_we  <= we[win];
        lat_a1  <= win ? addr1_1 : addr1_0;
        lat_a2  <= win ? addr2_1 : addr2_0;
        lat_wd  <= win ? wdata_1 : wdata_0;
      end
      if (state == ACCESS && !lat_we) begin
        rdata1 <= rf_data1;
        rdata2 <= rf_data2;
      end
    end
  end

  // Outputs: regfile controls live only in ACCESS; reset gates them so an in-flight write is dropped
  always_comb begin
    gnt        = '0;
    rvalid     = '0;
    rf_r_addr1 = '0;
    rf_r_addr2 = '0;
    rf_w_addr  = '0;
    rf_w_data  = '0;
    rf_r_or_w  = 1'b0;
    case (state)
      ACCESS: begin
        gnt = lat_sel ? 2'b10 : 2'b01;
        if (!reset) begin
          rf_r_or_w = lat_we;
          if (lat_we) begin
            rf_w_addr = lat_a1;
            rf_w_data = lat_wd;
          end else begin
            rf_r_addr1 = lat_a1;
            rf_r_addr2 = lat_a2;
          end
        end
      end
      RESP: begin
        if (!lat_we) rvalid = lat_sel ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x8 regfile attached.
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, we;
  logic [2:0] addr1_0, addr1_1, addr2_0, addr2_1;
  logic [7:0] wdata_0, wdata_1;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata1, rdata2;
  logic [2:0] rf_r_addr1, rf_r_addr2, rf_w_addr;
  logic [7:0] rf_w_data;
  logic       rf_r_or_w;
  logic [7:0] rf_data1, rf_data2;

  logic [7:0] mem [8];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
  always @(posedge clk) if (rf_r_or_w) mem[rf_w_addr] <= rf_w_data;
  assign rf_data1 = mem[rf_r_addr1];
  assign rf_data2 = mem[rf_r_addr2];

  regfile_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr1_0(addr1_0), .addr1_1(addr1_1), .addr2_0(addr2_0), .addr2_1(addr2_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt(gnt), .rvalid(rvalid), .rdata1(rdata1), .rdata2(rdata2),
    .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2), .rf_w_addr(rf_w_addr),
    .rf_w_data(rf_w_data), .rf_r_or_w(rf_r_or_w),
    .rf_data1(rf_data1), .rf_data2(rf_data2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // all outputs packed: gnt, rvalid, rdata1, rdata2, r_addr1, r_addr2, w_addr, w_data, r_or_w
  function automatic logic [45:0] outs();
    return {gnt, rvalid, rdata1, rdata2, rf_r_addr1, rf_r_addr2, rf_w_addr, rf_w_data, rf_r_or_w};
  endfunction

  task automatic test_reset();
    req = 2'b00; we = 2'b00;
    addr1_0 = '0; addr1_1 = '0; addr2_0 = '0; addr2_1 = '0;
    wdata_0 = '0; wdata_1 = '0;
    do_reset();
    total++;
    if (outs() !== 46'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", outs());
    end
    step();
    total++;
    if (gnt !== 2'b00) begin
      bad++; $display("FAIL reset_idle_gnt got=%b exp=00", gnt);
    end
  endtask

  task automatic test_write();
    req = 2'b01; we = 2'b01; addr1_0 = 3'd2; wdata_0 = 8'd63;
    step();
    req = 2'b00;
    total++;
    if ({gnt, rvalid, rf_r_or_w, rf_w_addr, rf_w_data} !== {2'b01, 2'b00, 1'b1, 3'd2, 8'd63}) begin
      bad++; $display("FAIL write_access got gnt=%b rv=%b rw=%b wa=%0d wd=%0d exp gnt=01 rv=00 rw=1 wa=2 wd=63",
                      gnt, rvalid, rf_r_or_w, rf_w_addr, rf_w_data);
    end
    step();
    total++;
    if ({gnt, rvalid, rf_r_or_w, rf_w_addr, rf_w_data} !== 15'd0) begin
      bad++; $display("FAIL write_resp got gnt=%b rv=%b rw=%b wa=%0d wd=%0d exp all 0",
                      gnt, rvalid, rf_r_or_w, rf_w_addr, rf_w_data);
    end
    step();
  endtask

  task automatic test_read();
    req = 2'b01; we = 2'b00; addr1_0 = 3'd2; addr2_0 = 3'd1;
    step();
    req = 2'b00;
    total++;
    if ({gnt, rvalid, rf_r_or_w, rf_r_addr1, rf_r_addr2} !== {2'b01, 2'b00, 1'b0, 3'd2, 3'd1}) begin
      bad++; $display("FAIL read_access got gnt=%b rv=%b rw=%b a1=%0d a2=%0d exp gnt=01 rv=00 rw=0 a1=2 a2=1",
                      gnt, rvalid, rf_r_or_w, rf_r_addr1, rf_r_addr2);
    end
    step();
    total++;
    if ({rvalid, rdata1, rdata2} !== {2'b01, 8'd63, 8'd0}) begin
      bad++; $display("FAIL read_resp got rv=%b d1=%0d d2=%0d exp rv=01 d1=63 d2=0", rvalid, rdata1, rdata2);
    end
    step();
    total++;
    if ({rvalid, rdata1} !== {2'b00, 8'd63}) begin
      bad++; $display("FAIL read_hold got rv=%b d1=%0d exp rv=00 d1=63", rvalid, rdata1);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req = 2'b11; we = 2'b01;
    addr1_0 = 3'd4; wdata_0 = 8'd31;
    addr1_1 = 3'd4; addr2_1 = 3'd2;
    step();
    total++;
    if (gnt !== 2'b01) begin
      bad++; $display("FAIL contention_first got=%b exp=01", gnt);
    end
    req = 2'b10;
    step();
    step();
    step();
    total++;
    if (gnt !== 2'b10) begin
      bad++; $display("FAIL contention_second got=%b exp=10", gnt);
    end
    req = 2'b00;
    step();
    total++;
    if ({rvalid, rdata1, rdata2} !== {2'b10, 8'd31, 8'd63}) begin
      bad++; $display("FAIL contention_read got rv=%b d1=%0d d2=%0d exp rv=10 d1=31 d2=63", rvalid, rdata1, rdata2);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    logic       exp_w;
    int         nbad;
    nbad = 0;
    req = 2'b11; we = 2'b11;
    addr1_0 = 3'd6; wdata_0 = 8'd1;
    addr1_1 = 3'd7; wdata_1 = 8'd2;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 12) req = 2'b00;
      exp_w = (k % 3 == 1);
      exp_g = !exp_w ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      total++;
      if ({gnt, rf_r_or_w} !== {exp_g, exp_w}) begin
        bad++; nbad++;
        $display("FAIL b2b_cycle%0d got gnt=%b rw=%b exp gnt=%b rw=%b", k, gnt, rf_r_or_w, exp_g, exp_w);
      end
    end
    step();
    total++;
    if ({mem[6], mem[7]} !== {8'd1, 8'd2}) begin
      bad++; $display("FAIL b2b_writes got m6=%0d m7=%0d exp m6=1 m7=2", mem[6], mem[7]);
    end
  endtask

  task automatic test_reset_during_write();
    req = 2'b01; we = 2'b01; addr1_0 = 3'd5; wdata_0 = 8'hAA;
    step();
    req = 2'b00;
    reset = 1'b1;
    #1;
    total++;
    if (rf_r_or_w !== 1'b0) begin
      bad++; $display("FAIL reset_gates_write got rw=%b exp rw=0", rf_r_or_w);
    end
    step();
    reset = 1'b0;
    total++;
    if (outs() !== 46'd0) begin
      bad++; $display("FAIL reset_midflight_outputs got=%h exp=0", outs());
    end
    req = 2'b01; we = 2'b00; addr1_0 = 3'd5; addr2_0 = 3'd4;
    step();
    req = 2'b00;
    step();
    total++;
    if ({rvalid, rdata1, rdata2} !== {2'b01, 8'd0, 8'd31}) begin
      bad++; $display("FAIL reset_write_dropped got rv=%b d1=%h d2=%0d exp rv=01 d1=00 d2=31", rvalid, rdata1, rdata2);
    end
    step();
  endtask

  task automatic test_last_priority();
    do_reset();
    req = 2'b10; we = 2'b00; addr1_1 = 3'd2; addr2_1 = 3'd6;
    step();
    req = 2'b00;
    total++;
    if (gnt !== 2'b10) begin
      bad++; $display("FAIL lone_req1 got=%b exp=10", gnt);
    end
    step();
    total++;
    if ({rvalid, rdata1, rdata2} !== {2'b10, 8'd63, 8'd1}) begin
      bad++; $display("FAIL lone_req1_read got rv=%b d1=%0d d2=%0d exp rv=10 d1=63 d2=1", rvalid, rdata1, rdata2);
    end
    step();
    req = 2'b11; we = 2'b00;
    step();
    req = 2'b00;
    total++;
    if (gnt !== 2'b01) begin
      bad++; $display("FAIL tie_after_req1 got=%b exp=01", gnt);
    end
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_back_to_back();
    test_reset_during_write();
    test_last_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8x8 `regfile`. The `regfile` has one address/data port set and a single `r_or_w` mode bit, so it performs either one write or one two-operand read per cycle. This block accepts read/write requests from two masters (e.g. core datapath and load/debug port), grants one at a time, drives the `regfile` controls, and returns read data with a valid strobe. It sits between the requesters and the `regfile` instance; nothing else drives `regfile` inputs.

## Interface
- `ADDR_W`, 3, register address width (8 registers)
- `DATA_W`, 8, register data width

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req[1:0]`  in  2  per-requester access request
- `we[1:0]`  in  2  per-requester op: 1 = write, 0 = read
- `addr1_0`, `addr1_1`  in  ADDR_W  read operand 1 address / write address, requester 0 / 1
- `addr2_0`, `addr2_1`  in  ADDR_W  read operand 2 address (ignored on write), requester 0 / 1
- `wdata_0`, `wdata_1`  in  DATA_W  write data, requester 0 / 1
- `gnt[1:0]`  out  2  one-cycle grant pulse, one-hot or zero
- `rvalid[1:0]`  out  2  one-cycle read-data-valid pulse
- `rdata1`, `rdata2`  out  DATA_W  captured read data, shared by both requesters, qualified by `rvalid`
- `rf_r_addr1`, `rf_r_addr2`, `rf_w_addr`  out  ADDR_W  to `regfile` `r_addr1`/`r_addr2`/`w_addr`
- `rf_w_data`  out  DATA_W  to `regfile` `w_data`
- `rf_r_or_w`  out  1  to `regfile` `r_or_w` (1 = write)
- `rf_data1`, `rf_data2`  in  DATA_W  from `regfile` `data1`/`data2`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `req` high at the clock edge, pick a winner, latch its `we`/addresses/data, raise its `gnt` bit for the next cycle, and go to ACCESS. If no `req` is high, stay in IDLE.
- Arbitration: round-robin over one priority bit `last`. Only one request -> that requester wins. Both requesting -> the requester not equal to `last` wins. `last` updates to the winner on grant. Reset: `last` = 1, so requester 0 wins the first tie.
- ACCESS: drive the latched request onto `rf_*`. `rf_r_or_w` = latched `we`. For a write, `rf_w_addr` = addr1 and `rf_w_data` = wdata; the write commits at the end of ACCESS. For a read, `rf_r_addr1`/`rf_r_addr2` = addr1/addr2; `rf_data1`/`rf_data2` are captured into `rdata1`/`rdata2` at the end of ACCESS. Always go to RESP.
- RESP: for a read, the winner's `rvalid` bit is high; for a write, `rvalid` stays 0. `rf_r_or_w` = 0. Go to IDLE.
- Outside ACCESS, all `rf_*` outputs are 0 (read mode, address 0). No write can occur outside ACCESS.
- `rdata1`/`rdata2` hold their value until the next read capture.
- Requester rule: `req` and operand fields are sampled only in IDLE. The requester must drop `req` by the cycle after `gnt`. A `req` still high in the next IDLE is a new request.
- `req` changes during ACCESS/RESP are ignored.

## Timing
- Reset values: state IDLE, `gnt`=0, `rvalid`=0, `rdata1`=`rdata2`=0, all `rf_*`=0, `last`=1.
- `req` sampled high at edge of cycle N (IDLE) -> `gnt` high in N+1 with state ACCESS -> `regfile` write commits, or read data captured, at the end of N+1 -> `rvalid` high in N+2 (reads) with state RESP -> IDLE in N+3.
- Peak throughput: one access per 3 cycles.
- Back-to-back contention: both `req` held high -> grants alternate 0,1,0,1 with 3-cycle spacing.
- `reset` high at any state -> IDLE next cycle with all outputs at reset values. An in-flight write in ACCESS during the reset cycle is not committed, because `rf_r_or_w` is forced to 0 that cycle.
- `regfile` read path is treated as combinational within ACCESS; its write is visible to a read issued in any later ACCESS.

## Test plan
- Reset, then req0 write addr 2 data 63 -> `gnt`=01 one cycle; `rf_r_or_w`=1, `rf_w_addr`=2, `rf_w_data`=63 for exactly one cycle; `rvalid`=00.
- After that, req0 read addr1=2 addr2=1 -> `rvalid`=01 two cycles after sampling; `rdata1`=63, `rdata2`=0.
- req0 and req1 raised together, both held: req0 writes addr 4 data 31, req1 reads 4/2 -> first `gnt`=01, next `gnt`=10 three cycles later; req1 gets `rvalid`=10 with `rdata1`=31, `rdata2`=63.
- Both held continuously for 4 grants -> `gnt` sequence 01,10,01,10; never 11; `rf_r_or_w` is 0 in every non-ACCESS cycle.
- Assert `reset` in the ACCESS cycle of a write to addr 5 data 0xAA, then read addr 5 -> `rdata1`=0 (write dropped); all outputs equal reset values in the cycle after reset.
- req1 alone right after reset, then a req0/req1 tie -> req1 wins first, then req0 wins the tie (`last`=1).
